// File: rtl/as_verdict_gate.sv
// Packet-verdict stage: pairs buffered packets with lookup verdicts, stamps or drops them.
// Optional macro AS_VERDICT_REDIRECT_EN forwards dropped packets to CPU_PORT_MASK.
`ifndef IO_QUEUE_STAGE_NUM
`define IO_QUEUE_STAGE_NUM 8'hff
`endif
`ifndef IOQ_DST_PORT_POS
`define IOQ_DST_PORT_POS 16
`endif

module as_verdict_gate #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH/8,
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int DATA_FIFO_DEPTH_BITS = 4,
  parameter int VERDICT_FIFO_DEPTH_BITS = 2,
  parameter int CNT_WIDTH = 32,
  parameter logic [NUM_OUTPUT_QUEUES-1:0] CPU_PORT_MASK = 8'b10101010
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [CTRL_WIDTH-1:0]        in_ctrl,
  input  logic                         in_wr,
  output logic                         in_rdy,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CTRL_WIDTH-1:0]        out_ctrl,
  output logic                         out_wr,
  input  logic                         out_rdy,
  input  logic                         verdict_valid,
  input  logic                         verdict_drop,
  input  logic [NUM_OUTPUT_QUEUES-1:0] verdict_dst_ports,
  output logic [CNT_WIDTH-1:0]         pass_count,
  output logic [CNT_WIDTH-1:0]         drop_count,
  output logic                         verdict_overflow
);

  localparam int DFB = DATA_FIFO_DEPTH_BITS;
  localparam int VFB = VERDICT_FIFO_DEPTH_BITS;
  localparam int NQ = NUM_OUTPUT_QUEUES;
  localparam int DDEPTH = 1 << DFB;
  localparam int VDEPTH = 1 << VFB;
  localparam int DWF = CTRL_WIDTH + DATA_WIDTH;
  localparam int VWF = 1 + NQ;
  localparam int DPOS = `IOQ_DST_PORT_POS;
  localparam logic [CTRL_WIDTH-1:0] IOQ_CTRL =
    CTRL_WIDTH'(`IO_QUEUE_STAGE_NUM);
  localparam logic [DFB:0] D_FULL = (DFB+1)'(DDEPTH);
  localparam logic [DFB:0] D_NFULL = (DFB+1)'(DDEPTH-1);
  localparam logic [VFB:0] V_FULL = (VFB+1)'(VDEPTH);
  localparam logic [VFB:0] V_NFULL = (VFB+1)'(VDEPTH-1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    BODY
  } state_t;

  state_t state_q, state_d;

  logic [DWF-1:0] dmem [DDEPTH];
  logic [VWF-1:0] vmem [VDEPTH];

  logic [DFB-1:0] dwp_q, dwp_d, drp_q, drp_d;
  logic [DFB:0]   dcnt_q, dcnt_d;
  logic [VFB-1:0] vwp_q, vwp_d, vrp_q, vrp_d;
  logic [VFB:0]   vcnt_q, vcnt_d;

  logic d_push, d_pop, d_empty, d_full;
  logic v_push, v_pop, v_empty, v_full;

  logic [CTRL_WIDTH-1:0] hd_ctrl;
  logic [DATA_WIDTH-1:0] hd_data, hd_mod;
  logic                  vh_drop;
  logic [NQ-1:0]         vh_ports, vh_ports_eff;

  logic          drop_q, drop_d;
  logic [NQ-1:0] ports_q, ports_d;
  logic          fwd;

  logic                  out_wr_q, out_wr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
  logic [CNT_WIDTH-1:0]  pass_q, pass_d, dropc_q, dropc_d;
  logic                  ovf_q, ovf_d;

  assign d_empty = (dcnt_q == '0);
  assign d_full = (dcnt_q == D_FULL);
  assign v_empty = (vcnt_q == '0);
  assign v_full = (vcnt_q == V_FULL);

  assign {hd_ctrl, hd_data} = dmem[drp_q];
  assign {vh_drop, vh_ports} = vmem[vrp_q];

  assign in_rdy = !reset && (dcnt_q < D_NFULL) && (vcnt_q < V_NFULL);

`ifdef AS_VERDICT_REDIRECT_EN
  assign fwd = 1'b1;
  assign vh_ports_eff = vh_drop ? CPU_PORT_MASK : vh_ports;
`else
  logic unused_cpu_mask;
  assign unused_cpu_mask = ^CPU_PORT_MASK;
  assign fwd = !drop_q;
  assign vh_ports_eff = vh_ports;
`endif

  always_comb begin
    d_push = in_wr && !d_full;
    dwp_d = d_push ? dwp_q + 1'b1 : dwp_q;
    drp_d = d_pop ? drp_q + 1'b1 : drp_q;
    dcnt_d = dcnt_q;
    if (d_push && !d_pop) dcnt_d = dcnt_q + 1'b1;
    if (!d_push && d_pop) dcnt_d = dcnt_q - 1'b1;
  end

  // a pop in the same cycle frees a slot, so a full FIFO still takes the push
  always_comb begin
    v_push = verdict_valid && (!v_full || v_pop);
    ovf_d = ovf_q || (verdict_valid && v_full && !v_pop);
    vwp_d = v_push ? vwp_q + 1'b1 : vwp_q;
    vrp_d = v_pop ? vrp_q + 1'b1 : vrp_q;
    vcnt_d = vcnt_q;
    if (v_push && !v_pop) vcnt_d = vcnt_q + 1'b1;
    if (!v_push && v_pop) vcnt_d = vcnt_q - 1'b1;
  end

  always_comb begin
    hd_mod = hd_data;
    if (hd_ctrl == IOQ_CTRL) hd_mod[DPOS +: NQ] = ports_q;
  end

  always_comb begin
    state_d = state_q;
    d_pop = 1'b0;
    v_pop = 1'b0;
    drop_d = drop_q;
    ports_d = ports_q;
    out_wr_d = 1'b0;
    out_data_d = out_data_q;
    out_ctrl_d = out_ctrl_q;
    pass_d = pass_q;
    dropc_d = dropc_q;
    unique case (state_q)
      IDLE: begin
        if (!v_empty && !d_empty) begin
          v_pop = 1'b1;
          drop_d = vh_drop;
          ports_d = vh_ports_eff;
          state_d = HDR;
        end
      end
      HDR, BODY: begin
        if (out_rdy && !d_empty) begin
          d_pop = 1'b1;
          out_wr_d = fwd;
          if (fwd) begin
            out_data_d = hd_mod;
            out_ctrl_d = hd_ctrl;
          end
          if (state_q == HDR) begin
            if (hd_ctrl == '0) state_d = BODY;
          end else if (hd_ctrl != '0) begin
            state_d = IDLE;
            if (drop_q) begin
              if (dropc_q != CNT_MAX) dropc_d = dropc_q + 1'b1;
            end else begin
              if (pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (d_push) dmem[dwp_q] <= {in_ctrl, in_data};
    if (v_push) vmem[vwp_q] <= {verdict_drop, verdict_dst_ports};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dwp_q <= '0;
      drp_q <= '0;
      dcnt_q <= '0;
      vwp_q <= '0;
      vrp_q <= '0;
      vcnt_q <= '0;
      drop_q <= 1'b0;
      ports_q <= '0;
      out_wr_q <= 1'b0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
      pass_q <= '0;
      dropc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dwp_q <= dwp_d;
      drp_q <= drp_d;
      dcnt_q <= dcnt_d;
      vwp_q <= vwp_d;
      vrp_q <= vrp_d;
      vcnt_q <= vcnt_d;
      drop_q <= drop_d;
      ports_q <= ports_d;
      out_wr_q <= out_wr_d;
      out_data_q <= out_data_d;
      out_ctrl_q <= out_ctrl_d;
      pass_q <= pass_d;
      dropc_q <= dropc_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_wr = out_wr_q;
  assign out_data = out_data_q;
  assign out_ctrl = out_ctrl_q;
  assign pass_count = pass_q;
  assign drop_count = dropc_q;
  assign verdict_overflow = ovf_q;

endmodule

// File: doc/as_verdict_gate.md
# as_verdict_gate

Parametrised packet-verdict stage for the anti-spoof datapath. Buffers incoming packets and pairs each one, in order, with a verdict from an external lookup: drop flag plus destination-port bitmap. Passed packets get the bitmap written into the IO-queue module header. Dropped packets are discarded and counted. Sits between the lookup and the output queues; it generalises the single-channel fixed-depth drop stage with configurable depths, counters and an overflow flag.

## Interface
- DATA_WIDTH, 64, datapath width
- CTRL_WIDTH, DATA_WIDTH/8, ctrl width
- NUM_OUTPUT_QUEUES, 8, width of destination-port bitmap
- DATA_FIFO_DEPTH_BITS, 4, log2 depth of packet-word FIFO
- VERDICT_FIFO_DEPTH_BITS, 2, log2 depth of verdict FIFO
- CNT_WIDTH, 32, width of pass/drop counters
- CPU_PORT_MASK, 8'b10101010, redirect bitmap (used only with AS_VERDICT_REDIRECT_EN)
- clk  in  1  sole clock; all logic rising-edge
- reset  in  1  asynchronous, active-high
- in_data / in_ctrl / in_wr  in  DATA_WIDTH / CTRL_WIDTH / 1  upstream word and strobe
- in_rdy  out  1  upstream may write
- out_data / out_ctrl / out_wr  out  DATA_WIDTH / CTRL_WIDTH / 1  downstream word and strobe, registered
- out_rdy  in  1  downstream can accept
- verdict_valid  in  1  one-cycle pulse, one per packet, in packet order
- verdict_drop  in  1  1 = drop packet
- verdict_dst_ports  in  NUM_OUTPUT_QUEUES  destination bitmap
- pass_count / drop_count  out  CNT_WIDTH  packets forwarded / discarded
- verdict_overflow  out  1  sticky: a verdict arrived while the verdict FIFO was full

## Operation
- Data FIFO: FWFT, written on in_wr. Verdict FIFO: FWFT, written on verdict_valid.
- in_rdy = !data_nearly_full && !verdict_nearly_full. Nearly-full means at most 1 free entry.
- Packet framing:
  - Module-header words have ctrl != 0.
  - The first word with ctrl == 0 starts the payload.
  - The first word after the payload has started with ctrl != 0 is EOP.
- FSM states: IDLE, HDR, BODY. Reset state is IDLE.
  - IDLE → HDR when verdict FIFO and data FIFO are both non-empty. The head verdict is latched (drop_l, ports_l) and popped that cycle.
  - HDR: while out_rdy && data FIFO non-empty, pop one word.
    - If ctrl == `IO_QUEUE_STAGE_NUM, replace bits [`IOQ_DST_PORT_POS+NUM_OUTPUT_QUEUES-1:`IOQ_DST_PORT_POS] with ports_l. All other bits are unchanged.
    - On a popped word with ctrl == 0: → BODY.
  - BODY: pop under the same condition. On the popped EOP word: → IDLE.
    - In the same cycle, increment pass_count (drop_l=0) or drop_count (drop_l=1).
- Forwarding: a popped word is written downstream only when drop_l = 0. Dropped packets drain at one word per cycle with out_wr held at 0.
  - Drop-mode popping still requires out_rdy, so ordering stays simple.
- Counters saturate at all-ones; they do not wrap.
- A verdict_valid while the verdict FIFO is full:
  - the verdict is discarded;
  - verdict_overflow is set and stays set until reset.
- Simultaneous verdict push and pop is legal, including when the FIFO is full: the pop frees the slot first and the push is accepted.

## Timing
- Outputs are registered: a word popped in cycle N appears with out_wr=1 in cycle N+1.
- out_rdy is sampled in cycle N. Downstream must tolerate one extra word after deasserting out_rdy.
- Minimum packet latency is 2 cycles, measured from both FIFOs non-empty to first out_wr.
- Throughput: one word per cycle; no bubble between back-to-back packets beyond the single IDLE cycle.
- Reset values: out_wr=0, out_data=0, out_ctrl=0, in_rdy=0 while reset is asserted, counters=0, verdict_overflow=0, both FIFOs empty, state IDLE.
- Reset asserted mid-packet aborts immediately. After release, the remnant words are gone; upstream must restart on a packet boundary.

## Configuration
- AS_VERDICT_REDIRECT_EN
  - Defined: verdict_drop=1 packets are forwarded, not discarded. The destination field is overwritten with CPU_PORT_MASK instead of ports_l. drop_count still increments.
  - Undefined: dropped packets are discarded as described above, and CPU_PORT_MASK is unused.

## Test plan
- Pass: 8-word packet with IOQ header, verdict drop=0, ports=8'h04 → 8 out_wr. Header bits [23:16]=8'h04, all other words bit-identical. pass_count=1.
- Drop: same packet with drop=1 → zero out_wr, drop_count=1. The next packet with drop=0 emerges intact.
- Backpressure: out_rdy toggled 1/0 every cycle across a 64-byte packet → no word lost or duplicated, order preserved, at most one word emitted after each out_rdy fall.
- Verdict overflow: 5 verdicts pushed with VERDICT_FIFO_DEPTH_BITS=2 and no packets → verdict_overflow=1; first 4 verdicts retained.
- Redirect (macro defined): packet with drop=1, ports=8'h01 → forwarded with header field 8'hAA, drop_count=1.
- Async reset mid-BODY → out_wr=0 within the same cycle, counters 0. A fresh packet plus verdict after release passes correctly.
